// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : arb_pkg
// Description : Shared types and helpers for the rr_grant_sequencer arbiter.
//               State enum (one grant state per requester), requester count,
//               and the round-robin pick function.
//               The state encoding is chosen so that a grant state's index
//               equals (state - 1), and S_IDLE maps to index 3 (the idle
//               owner code).
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int N_REQ = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_G0   = 2'd1,
        S_G1   = 2'd2,
        S_G2   = 2'd3
    } arb_state_t;

    // Next index to grant: first set bit of req searched from last+1 (mod 3).
    // Returns 3 when nothing is requesting.
    function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] req,
                                           input logic [1:0]       last);
        int c;
        rr_pick = 2'd3;
        // Walk from the farthest candidate to the nearest so the nearest wins.
        for (int i = N_REQ; i >= 1; i--) begin
            c = (int'(last) + i) % N_REQ;
            if (req[c]) begin
                rr_pick = 2'(c);
            end
        end
    endfunction

    // Grant state -> requester index; S_IDLE yields 3.
    function automatic logic [1:0] state_idx(input arb_state_t s);
        state_idx = 2'(s) - 2'd1;
    endfunction

    // Requester index -> grant state; index 3 yields S_IDLE.
    function automatic arb_state_t idx_state(input logic [1:0] idx);
        idx_state = arb_state_t'(idx + 2'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : arb_hold_timer
// Description : Tenure counter for the arbiter. Cleared on grant entry,
//               counts while enabled and saturates at MAX_HOLD-1.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               clear         - zero the count (grant entry / exit)
//               enable        - count this cycle (a grant is active)
//               expired       - count == MAX_HOLD-1
// Revision    : 1.0 - initial release
// ============================================================================
module arb_hold_timer #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = $clog2(MAX_HOLD)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && (r_cnt != c_last)) begin
            // Saturate rather than wrap; the FSM releases on expiry anyway.
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/rr_grant_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_sequencer
// Description : Three-requester round-robin arbiter with a bounded tenure.
//               Registered one-hot grant, rotation 0->1->2->0 skipping idle
//               requesters, direct handoff on release, forced release after
//               MAX_HOLD grant cycles.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               req[2:0]  - level requests
//               done[2:0] - release, honoured only for the current owner
//               gnt[2:0]  - registered grant, one-hot or zero
//               owner     - current owner index, 3 when idle
//               busy      - any grant active
//               timeout   - one-cycle pulse after a counter-only release
// Config      : ARB_TRACE_EN - when defined, prints each state change with
//               its cause; cycle behaviour is unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_sequencer
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = $clog2(MAX_HOLD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic [1:0]       owner,
    output logic             busy,
    output logic             timeout
);

    arb_state_t       r_state;
    logic [1:0]       r_last;
    logic [N_REQ-1:0] r_gnt;
    logic [1:0]       r_owner;
    logic             r_busy;
    logic             r_timeout;

    arb_state_t       w_next;
    logic             w_in_grant;
    logic [1:0]       w_k;
    logic [N_REQ-1:0] w_k_oh;
    logic             w_req_k;
    logic             w_done_k;
    logic             w_expired;
    logic             w_release;
    logic             w_forced;
    logic [1:0]       w_pick;

    always_comb begin
        w_in_grant = (r_state != S_IDLE);
        w_k        = state_idx(r_state);
        // Index 3 shifts out entirely, so idle selects no requester.
        w_k_oh     = N_REQ'(3'b001 << w_k);
        w_req_k    = |(req & w_k_oh);
        w_done_k   = |(done & w_k_oh);
        w_release  = w_in_grant && (w_done_k || !w_req_k || w_expired);
        w_forced   = w_in_grant && w_expired && !w_done_k && w_req_k;
        // On a handoff the releasing requester is masked out, so it can
        // never be re-granted on the same edge.
        if (w_in_grant) begin
            w_pick = rr_pick(req & ~w_k_oh, w_k);
        end else begin
            w_pick = rr_pick(req, r_last);
        end
        if (!w_in_grant || w_release) begin
            w_next = idx_state(w_pick);
        end else begin
            w_next = r_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_last    <= 2'd2;
            r_gnt     <= '0;
            r_owner   <= 2'd3;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_gnt     <= N_REQ'(3'b001 << state_idx(w_next));
            r_owner   <= state_idx(w_next);
            r_busy    <= (w_next != S_IDLE);
            r_timeout <= w_forced;
            if (w_release) begin
                r_last <= w_k;
            end
        end
    end

    // Every state change is either a grant entry, a handoff or a return to
    // idle, so clearing on change gives a fresh count for each tenure.
    arb_hold_timer #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_next != r_state),
        .enable  (w_in_grant),
        .expired (w_expired)
    );

    assign gnt     = r_gnt;
    assign owner   = r_owner;
    assign busy    = r_busy;
    assign timeout = r_timeout;

`ifdef ARB_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst && (w_next != r_state)) begin
            if (!w_in_grant) begin
                $display("%0t arb: %s -> %s cause=req", $time, r_state.name(), w_next.name());
            end else if (w_done_k) begin
                $display("%0t arb: %s -> %s cause=done", $time, r_state.name(), w_next.name());
            end else if (!w_req_k) begin
                $display("%0t arb: %s -> %s cause=drop", $time, r_state.name(), w_next.name());
            end else begin
                $display("%0t arb: %s -> %s cause=timeout", $time, r_state.name(), w_next.name());
            end
        end
    end
`else
    // Trace disabled: no display logic is built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_grant_sequencer
// Description : Self-checking bench for rr_grant_sequencer (MAX_HOLD=4).
//               Directed vector table, hand-written corner sequences, then
//               randomized traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_grant_sequencer;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [2:0] done;
    logic [2:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;

    int n_vec;
    int n_err;

    // Reference model state: owner (3 = idle), cycles held so far, pointer.
    int   m_owner;
    int   m_ten;
    int   m_last;
    logic m_to;

    rr_grant_sequencer #(
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic [2:0] done;
        logic [2:0] gnt;
        logic [1:0] owner;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t tbl[23];

    function automatic int pick(input logic [2:0] rq, input int last);
        for (int i = 1; i <= 3; i++) begin
            if (rq[(last + i) % 3]) return (last + i) % 3;
        end
        return 3;
    endfunction

    task automatic model_step(input logic r, input logic [2:0] rq, input logic [2:0] dn);
        int nxt;
        if (r) begin
            m_owner = 3; m_ten = 0; m_last = 2; m_to = 1'b0;
            return;
        end
        m_to = 1'b0;
        if (m_owner == 3) begin
            nxt = pick(rq, m_last);
            if (nxt != 3) begin
                m_owner = nxt;
                m_ten   = 1;
            end
        end else if (dn[m_owner] || !rq[m_owner] || m_ten == MAX_HOLD) begin
            m_to    = (m_ten == MAX_HOLD) && !dn[m_owner] && rq[m_owner];
            m_last  = m_owner;
            nxt     = pick(rq & ~(3'b001 << m_owner), m_owner);
            m_owner = nxt;
            m_ten   = (nxt == 3) ? 0 : 1;
        end else begin
            m_ten++;
        end
    endtask

    // One clock: drive inputs, advance model, sample outputs 1 time unit
    // after the edge.
    task automatic step(input logic r, input logic [2:0] rq, input logic [2:0] dn);
        rst = r; req = rq; done = dn;
        @(posedge clk);
        model_step(r, rq, dn);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] eg, input logic [1:0] eo,
                         input logic eb, input logic et);
        n_vec++;
        if (gnt !== eg || owner !== eo || busy !== eb || timeout !== et) begin
            n_err++;
            $display("FAIL %s: got gnt=%b owner=%0d busy=%b timeout=%b, expected gnt=%b owner=%0d busy=%b timeout=%b",
                     name, gnt, owner, busy, timeout, eg, eo, eb, et);
        end
    endtask

    task automatic check_model(input string name);
        logic [2:0] eg;
        eg = (m_owner == 3) ? 3'b000 : 3'(3'b001 << m_owner);
        check(name, eg, 2'(m_owner), m_owner != 3, m_to);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1; req = '0; done = '0;
        m_owner = 3; m_ten = 0; m_last = 2; m_to = 1'b0;

        // Reset/idle
        tbl[0]  = '{1'b1, 3'b111, 3'b000, 3'b000, 2'd3, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 3'b111, 3'b000, 3'b000, 2'd3, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 3'b111, 3'b000, 3'b001, 2'd0, 1'b1, 1'b0};
        // Rotation under steady load, forced releases every 4 cycles
        tbl[3]  = '{1'b0, 3'b111, 3'b000, 3'b001, 2'd0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 3'b111, 3'b000, 3'b001, 2'd0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 3'b111, 3'b000, 3'b001, 2'd0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 3'b111, 3'b000, 3'b010, 2'd1, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 3'b111, 3'b000, 3'b010, 2'd1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 3'b111, 3'b000, 3'b010, 2'd1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 3'b111, 3'b000, 3'b010, 2'd1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 3'b111, 3'b000, 3'b100, 2'd2, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 3'b111, 3'b000, 3'b100, 2'd2, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 3'b111, 3'b000, 3'b100, 2'd2, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 3'b111, 3'b000, 3'b100, 2'd2, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 3'b111, 3'b000, 3'b001, 2'd0, 1'b1, 1'b1};
        // Early release: done[0] on the 2nd grant cycle, no idle gap
        tbl[15] = '{1'b0, 3'b011, 3'b000, 3'b001, 2'd0, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 3'b011, 3'b001, 3'b010, 2'd1, 1'b1, 1'b0};
        // Skip/idle return
        tbl[17] = '{1'b0, 3'b100, 3'b000, 3'b100, 2'd2, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 3'b100, 3'b000, 3'b100, 2'd2, 1'b1, 1'b0};
        tbl[19] = '{1'b0, 3'b000, 3'b000, 3'b000, 2'd3, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 3'b000, 3'b000, 3'b000, 2'd3, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 3'b001, 3'b000, 3'b001, 2'd0, 1'b1, 1'b0};
        tbl[22] = '{1'b0, 3'b000, 3'b000, 3'b000, 2'd3, 1'b0, 1'b0};

        @(negedge clk);
        for (int i = 0; i < 23; i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].done);
            check($sformatf("table[%0d]", i), tbl[i].gnt, tbl[i].owner, tbl[i].busy, tbl[i].to);
        end

        // Foreign done ignored, then done[1] coinciding with expiry
        step(1'b0, 3'b011, 3'b000); check("foreign_t1", 3'b010, 2'd1, 1'b1, 1'b0);
        step(1'b0, 3'b011, 3'b101); check("foreign_t2", 3'b010, 2'd1, 1'b1, 1'b0);
        step(1'b0, 3'b011, 3'b101); check("foreign_t3", 3'b010, 2'd1, 1'b1, 1'b0);
        step(1'b0, 3'b011, 3'b101); check("foreign_t4", 3'b010, 2'd1, 1'b1, 1'b0);
        step(1'b0, 3'b011, 3'b010); check("tie_release", 3'b001, 2'd0, 1'b1, 1'b0);

        // Reset mid-grant on owner 2's third hold cycle
        step(1'b0, 3'b100, 3'b000); check("to_owner2", 3'b100, 2'd2, 1'b1, 1'b0);
        step(1'b0, 3'b100, 3'b000); check("owner2_t2", 3'b100, 2'd2, 1'b1, 1'b0);
        step(1'b0, 3'b100, 3'b000); check("owner2_t3", 3'b100, 2'd2, 1'b1, 1'b0);
        step(1'b1, 3'b111, 3'b000); check("mid_reset", 3'b000, 2'd3, 1'b0, 1'b0);
        step(1'b0, 3'b111, 3'b000); check("post_reset", 3'b001, 2'd0, 1'b1, 1'b0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            logic       r;
            logic [2:0] rq;
            logic [2:0] dn;
            r  = ($urandom_range(0, 59) == 0);
            rq = 3'($urandom);
            if ($urandom_range(0, 3) == 0) rq = 3'b111;
            dn = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            step(r, rq, dn);
            check_model($sformatf("random[%0d]", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
